// File: rtl/extmem_sched_pkg.sv
// extmem_sched_pkg: shared types and sizes for the external-memory burst scheduler.
// Rev 1.0
`default_nettype none

package extmem_sched_pkg;

  localparam int N_REQ_DEF = 3;
  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 16;
  localparam int LW_DEF    = 32;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IW = id_width(N_REQ_DEF);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [AW_DEF-1:0] addr;
    logic [LW_DEF-1:0] len;
    logic [IW-1:0]     id;
  } burst_desc_t;

endpackage

`default_nettype wire

// File: rtl/extmem_scheduler_if.sv
// extmem_scheduler_if: requester-side and extmem-side signals of the burst scheduler.
// Rev 1.0
`default_nettype none

interface extmem_scheduler_if
  import extmem_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int LW    = LW_DEF,
  parameter int IW    = extmem_sched_pkg::IW
) ();

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_write;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*LW-1:0] req_len;
  logic [N_REQ-1:0]    wr_valid;
  logic [N_REQ*DW-1:0] wr_data;
  logic [N_REQ-1:0]    wr_ready;
  logic                rd_valid;
  logic [IW-1:0]       rd_id;
  logic [DW-1:0]       rd_data;
  logic [N_REQ-1:0]    burst_done;
  logic                busy;
  logic                em_re;
  logic [AW-1:0]       em_rd_addr;
  logic [DW-1:0]       em_rd_data;
  logic                em_we;
  logic [AW-1:0]       em_wr_addr;
  logic [DW-1:0]       em_wr_data;

  // Requesters plus the memory model.
  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, em_rd_data,
    input  req_ready, wr_ready, rd_valid, rd_id, rd_data, burst_done, busy,
    input  em_re, em_rd_addr, em_we, em_wr_addr, em_wr_data
  );

  // The scheduler.
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, em_rd_data,
    output req_ready, wr_ready, rd_valid, rd_id, rd_data, burst_done, busy,
    output em_re, em_rd_addr, em_we, em_wr_addr, em_wr_data
  );

endinterface

`default_nettype wire

// File: rtl/extmem_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap.
// Rev 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [IW-1:0]    ptr,
  output logic      [N_REQ-1:0] grant,
  output logic      [IW-1:0]    grant_id,
  output logic                  grant_valid
);

  int w_cand;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    w_cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = (int'(ptr) + k) % N_REQ;
      if (!grant_valid && req[w_cand]) begin
        grant_valid   = 1'b1;
        grant[w_cand] = 1'b1;
        grant_id      = IW'(w_cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/extmem_scheduler.sv
// extmem_scheduler: arbitrates read/write bursts onto the single extmem port and tags read returns.
// Rev 1.0
`default_nettype none

module extmem_scheduler
  import extmem_sched_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int LW     = LW_DEF,
  parameter int RD_LAT = 1
) (
  input wire logic          clk,
  input wire logic          rst,
  extmem_scheduler_if.slave bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IW-1:0]    r_ptr;
  burst_desc_t      r_desc;
  burst_desc_t      w_desc_in;
  logic [LW-1:0]    r_idx;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_gid;
  logic             w_gvalid;

  logic             w_accept;
  logic             w_done;
  logic             w_beat;
  logic             w_issue_rd;
  logic             w_last_idx;
  logic             w_wr_open;
  logic             w_pipe_empty;
  logic [N_REQ-1:0] w_id_hot;

  logic             r_em_re;
  logic             r_em_we;
  logic [AW-1:0]    r_em_rd_addr;
  logic [AW-1:0]    r_em_wr_addr;
  logic [DW-1:0]    r_em_wr_data;

  logic [RD_LAT-1:0] r_lat_v;
  logic [IW-1:0]     r_lat_id [RD_LAT];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req         (bus.req_valid),
    .ptr         (r_ptr),
    .grant       (w_grant),
    .grant_id    (w_gid),
    .grant_valid (w_gvalid)
  );

  // Only the granted requester's slice is ever sampled.
  always_comb begin
    w_desc_in       = '0;
    w_desc_in.write = bus.req_write[w_gid];
    w_desc_in.addr  = bus.req_addr[w_gid*AW +: AW];
    w_desc_in.len   = bus.req_len[w_gid*LW +: LW];
    w_desc_in.id    = w_gid;
  end

  assign w_id_hot     = N_REQ'(1) << r_desc.id;
  assign w_last_idx   = (r_idx == r_desc.len - LW'(1));
  assign w_issue_rd   = (r_state == RD_BURST);
  assign w_wr_open    = (r_state == WR_BURST) && r_desc.write && (r_idx < r_desc.len);
  assign w_beat       = w_wr_open && bus.wr_valid[r_desc.id];
  // In-flight reads and the final registered write must both have left before completion.
  assign w_pipe_empty = !r_em_re && !r_em_we && (r_lat_v == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gvalid) begin
          w_accept = 1'b1;
          if (w_desc_in.len == '0) begin
            w_state_nxt = DRAIN;
          end else if (w_desc_in.write) begin
            w_state_nxt = WR_BURST;
          end else begin
            w_state_nxt = RD_BURST;
          end
        end
      end
      RD_BURST: begin
        if (w_last_idx) w_state_nxt = DRAIN;
      end
      WR_BURST: begin
        if (w_beat && w_last_idx) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_pipe_empty) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_desc       <= '0;
      r_idx        <= '0;
      r_em_re      <= 1'b0;
      r_em_we      <= 1'b0;
      r_em_rd_addr <= '0;
      r_em_wr_addr <= '0;
      r_em_wr_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_desc <= w_desc_in;
        r_idx  <= '0;
        r_ptr  <= (w_gid == IW'(N_REQ - 1)) ? '0 : w_gid + IW'(1);
      end else if (w_issue_rd || w_beat) begin
        r_idx <= r_idx + LW'(1);
      end
      r_em_re <= w_issue_rd;
      if (w_issue_rd) r_em_rd_addr <= r_desc.addr + AW'(r_idx);
      r_em_we <= w_beat;
      if (w_beat) begin
        r_em_wr_addr <= r_desc.addr + AW'(r_idx);
        r_em_wr_data <= bus.wr_data[r_desc.id*DW +: DW];
      end
    end
  end

  // Tag pipeline runs behind the registered strobe so its tap lines up with em_rd_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_v <= '0;
      for (int i = 0; i < RD_LAT; i++) r_lat_id[i] <= '0;
    end else begin
      r_lat_v[0]  <= r_em_re;
      r_lat_id[0] <= r_desc.id;
      for (int i = 1; i < RD_LAT; i++) begin
        r_lat_v[i]  <= r_lat_v[i-1];
        r_lat_id[i] <= r_lat_id[i-1];
      end
    end
  end

  assign bus.req_ready  = ((r_state == IDLE) && rst) ? w_grant : '0;
  assign bus.wr_ready   = w_wr_open ? w_id_hot : '0;
  assign bus.burst_done = w_done ? w_id_hot : '0;
  assign bus.busy       = (r_state != IDLE);
  assign bus.rd_valid   = r_lat_v[RD_LAT-1];
  assign bus.rd_id      = r_lat_id[RD_LAT-1];
  assign bus.rd_data    = r_lat_v[RD_LAT-1] ? bus.em_rd_data : '0;
  assign bus.em_re      = r_em_re;
  assign bus.em_rd_addr = r_em_rd_addr;
  assign bus.em_we      = r_em_we;
  assign bus.em_wr_addr = r_em_wr_addr;
  assign bus.em_wr_data = r_em_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_extmem_scheduler.sv
// tb_extmem_scheduler: scoreboard bench for extmem_scheduler with a 2-cycle read-latency memory.
// Rev 1.0
`default_nettype none

module tb_extmem_scheduler;
  import extmem_sched_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int LW  = 32;
  localparam int RDL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  extmem_scheduler_if #(.N_REQ(N), .AW(AW), .DW(DW), .LW(LW), .IW(IW)) bus ();

  extmem_scheduler #(
    .N_REQ(N), .AW(AW), .DW(DW), .LW(LW), .RD_LAT(RDL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  logic [15:0] p0, p1;
  always @(posedge clk) begin
    p0 <= bus.em_re ? mem_word(bus.em_rd_addr) : 16'h0;
    p1 <= p0;
  end
  assign bus.em_rd_data = p1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] q_ra[$];
  logic [47:0] q_wr[$];
  logic [17:0] q_rd[$];
  logic [2:0]  q_done[$];
  logic [2:0]  q_grant[$];

  int re_cnt = 0, we_cnt = 0, cur_run = 0, last_run = 0;
  int last_rdv_cyc = 0, done_cyc = 0, grant_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (bus.em_re || bus.em_we) chk("re_we_exclusive", bus.em_re & bus.em_we, 0);
    if (bus.em_re) begin
      re_cnt++;
      cur_run++;
      chk("em_re_expected", q_ra.size() != 0, 1);
      if (q_ra.size() != 0) chk("em_rd_addr", bus.em_rd_addr, q_ra.pop_front());
    end else if (cur_run > 0) begin
      last_run = cur_run;
      cur_run  = 0;
    end
    if (bus.em_we) begin
      we_cnt++;
      chk("we_before_reads_done", q_rd.size(), 0);
      chk("em_we_expected", q_wr.size() != 0, 1);
      if (q_wr.size() != 0) chk("em_wr_addr_data", {bus.em_wr_addr, bus.em_wr_data}, q_wr.pop_front());
    end
    if (bus.rd_valid) begin
      last_rdv_cyc = cyc;
      chk("rd_expected", q_rd.size() != 0, 1);
      if (q_rd.size() != 0) chk("rd_id_data", {bus.rd_id, bus.rd_data}, q_rd.pop_front());
    end
    if (bus.burst_done != '0) begin
      done_cyc = cyc;
      chk("done_expected", q_done.size() != 0, 1);
      if (q_done.size() != 0) chk("burst_done", bus.burst_done, q_done.pop_front());
    end
    if (bus.req_ready != '0) begin
      grant_cyc = cyc;
      chk("grant_expected", q_grant.size() != 0, 1);
      if (q_grant.size() != 0) chk("req_ready", bus.req_ready, q_grant.pop_front());
    end
  end

  task automatic exp_read(input int id, input logic [31:0] addr, input int len);
    logic [31:0] a;
    q_grant.push_back(3'(1 << id));
    for (int i = 0; i < len; i++) begin
      a = addr + 32'(i);
      q_ra.push_back(a);
      q_rd.push_back({2'(id), mem_word(a)});
    end
    q_done.push_back(3'(1 << id));
  endtask

  task automatic issue(input int id, input bit w, input logic [31:0] addr, input logic [31:0] len);
    bit got;
    got = 1'b0;
    bus.req_write[id]          = w;
    bus.req_addr[id*AW +: AW]  = addr;
    bus.req_len[id*LW +: LW]   = len;
    bus.req_valid[id]          = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[id]) got = 1'b1;
    end
    chk("grant_seen", got, 1);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic beat(input int id, input logic [15:0] d);
    bit got;
    got = 1'b0;
    bus.wr_valid[id]         = 1'b1;
    bus.wr_data[id*DW +: DW] = d;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.wr_ready[id]) got = 1'b1;
    end
    chk("wr_ready_seen", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk); #2;
      if (q_ra.size() == 0 && q_wr.size() == 0 && q_rd.size() == 0 &&
          q_done.size() == 0 && q_grant.size() == 0 && !bus.busy) ok = 1'b1;
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ctrl"}, {bus.req_ready, bus.wr_ready, bus.rd_valid, bus.rd_id, bus.rd_data,
                          bus.burst_done, bus.busy, bus.em_re, bus.em_we}, 0);
    chk({name, "_rd_addr"}, bus.em_rd_addr, 0);
    chk({name, "_wr"}, {bus.em_wr_addr, bus.em_wr_data}, 0);
  endtask

  initial begin
    int n;
    bit got;
    logic [2:0] g;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid  = '0; bus.wr_data   = '0;

    repeat (3) @(posedge clk);
    #1 chk_reset("reset_state");
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Read burst, 4 words.
    exp_read(0, 32'h100, 4);
    issue(0, 1'b0, 32'h100, 4);
    wait_idle();
    chk("re_run_len", last_run, 4);
    chk("done_after_last_rdv", done_cyc - last_rdv_cyc, 1);

    // Write burst with a 2-cycle stall after the first beat.
    q_grant.push_back(3'b010);
    q_wr.push_back({32'h20, 16'h1111});
    q_wr.push_back({32'h21, 16'h2222});
    q_wr.push_back({32'h22, 16'h3333});
    q_done.push_back(3'b010);
    n = we_cnt;
    fork
      issue(1, 1'b1, 32'h20, 3);
      begin
        beat(1, 16'h1111);
        bus.wr_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        beat(1, 16'h2222);
        beat(1, 16'h3333);
        bus.wr_valid[1] = 1'b0;
      end
    join
    wait_idle();
    chk("we_count", we_cnt - n, 3);

    // Zero-length request.
    q_grant.push_back(3'b100);
    q_done.push_back(3'b100);
    n = re_cnt + we_cnt;
    issue(2, 1'b0, 32'h50, 0);
    wait_idle();
    chk("len0_done_latency", done_cyc - grant_cyc, 1);
    chk("len0_no_strobes", re_cnt + we_cnt - n, 0);

    // Round robin with all three requesting.
    exp_read(0, 32'h10, 1);
    exp_read(1, 32'h11, 1);
    exp_read(2, 32'h12, 1);
    exp_read(0, 32'h10, 1);
    for (int i = 0; i < N; i++) begin
      bus.req_write[i]         = 1'b0;
      bus.req_addr[i*AW +: AW] = 32'h10 + 32'(i);
      bus.req_len[i*LW +: LW]  = 32'd1;
    end
    bus.req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      g   = '0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        if (bus.req_ready != '0) begin
          got = 1'b1;
          g   = bus.req_ready;
        end
      end
      chk("rr_grant_seen", got, 1);
      @(posedge clk); #1;
      if (k > 0) bus.req_valid = bus.req_valid & ~g;
    end
    bus.req_valid = '0;
    wait_idle();

    // Address wrap.
    exp_read(0, 32'hFFFF_FFFF, 2);
    issue(0, 1'b0, 32'hFFFF_FFFF, 2);
    wait_idle();

    // Reset after two strobes of an 8-word read.
    q_grant.push_back(3'b001);
    q_ra.push_back(32'h200);
    q_ra.push_back(32'h201);
    n = re_cnt;
    issue(0, 1'b0, 32'h200, 8);
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk); #1;
      if (re_cnt - n >= 2) got = 1'b1;
    end
    rst = 1'b0;
    #1 chk_reset("reset_mid");
    chk("strobes_before_reset", re_cnt - n, 2);
    q_ra.delete(); q_rd.delete(); q_wr.delete(); q_done.delete(); q_grant.delete();
    n = re_cnt + we_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("no_strobes_after_reset", re_cnt + we_cnt - n, 0);
    chk("idle_after_reset", bus.busy, 0);

    exp_read(2, 32'h300, 2);
    issue(2, 1'b0, 32'h300, 2);
    wait_idle();

    // Read then write back to back.
    exp_read(0, 32'h400, 2);
    q_grant.push_back(3'b010);
    q_wr.push_back({32'h500, 16'hBEEF});
    q_wr.push_back({32'h501, 16'hCAFE});
    q_done.push_back(3'b010);
    fork
      issue(0, 1'b0, 32'h400, 2);
      issue(1, 1'b1, 32'h500, 2);
      begin
        beat(1, 16'hBEEF);
        beat(1, 16'hCAFE);
        bus.wr_valid[1] = 1'b0;
      end
    join
    wait_idle();

    chk("queues_drained", q_ra.size() + q_wr.size() + q_rd.size() + q_done.size() + q_grant.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
